// File: rtl/packet_pkg.sv
// Shared packet and scheduler types for the 4-port switch: parser classes,
// per-input scheduler states and port-count constants.
package packet_pkg;

  localparam int ADDR_WIDTH           = 4;
  localparam int NUM_PORTS            = ADDR_WIDTH;
  localparam int DEFAULT_STARVE_LIMIT = 15;

  typedef enum logic [1:0] {
    SDP = 2'd0,
    MDP = 2'd1,
    BDP = 2'd2,
    ERR = 2'd3
  } p_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_alloc.sv
// Combinational allocator: scans candidates from start_i and grants each one whose
// whole output mask is still available, consuming those outputs for later candidates.
module rr_alloc #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        cand_i,
  input  logic [N-1:0][N-1:0] mask_i,
  input  logic [N-1:0]        free_i,
  input  logic [PW-1:0]       start_i,
  output logic [N-1:0]        grant_o,
  output logic [N-1:0][N-1:0] owner_o,
  output logic                any_o,
  output logic [PW-1:0]       first_o
);

  logic [N-1:0] avail;
  int           idx;

  // first_o records the first grant in scan order, which drives the pointer update
  always_comb begin
    grant_o = '0;
    owner_o = '0;
    any_o   = 1'b0;
    first_o = '0;
    avail   = free_i;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start_i) + k) % N;
      if (cand_i[idx] && ((mask_i[idx] & ~avail) == '0)) begin
        grant_o[idx] = 1'b1;
        avail        = avail & ~mask_i[idx];
        for (int o = 0; o < N; o++) begin
          if (mask_i[idx][o]) owner_o[o][idx] = 1'b1;
        end
        if (!any_o) begin
          any_o   = 1'b1;
          first_o = PW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/switch_scheduler.sv
// Output-port scheduler: per-input IDLE/WAIT/XFER FSMs with atomic round-robin
// output allocation. Define SCHED_STARVE_EN to add starvation-priority scheduling.
module switch_scheduler
  import packet_pkg::*;
#(
  parameter int NUM_PORTS    = packet_pkg::NUM_PORTS,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                req_valid,
  input  p_type                               req_type [NUM_PORTS],
  input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_target,
  input  logic [NUM_PORTS-1:0]                eop,
  output logic [NUM_PORTS-1:0]                grant,
  output logic [NUM_PORTS-1:0]                err_drop,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0] out_sel,
  output logic [NUM_PORTS-1:0]                out_busy,
  output logic [NUM_PORTS-1:0]                starve
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  sched_state_t state_q [NUM_PORTS];
  sched_state_t state_d [NUM_PORTS];
  logic [PW-1:0] rrPtr_q, rrPtr_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d, errDrop_q, errDrop_d;
  logic [NUM_PORTS-1:0] busy_q, busy_d, starve_q, starve_d;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] outSel_q, outSel_d;

  logic [NUM_PORTS-1:0] xferEop, badReq, cand, releaseMask, freeMask;
  logic [NUM_PORTS-1:0] allocGrant;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] allocOwner;
  logic allocAny;
  logic [PW-1:0] allocFirst;

  // Outputs released by eop this cycle count as free for the same-cycle scan
  always_comb begin
    xferEop     = '0;
    badReq      = '0;
    cand        = '0;
    releaseMask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      xferEop[i] = eop[i] && (state_q[i] == XFER);
      badReq[i]  = (state_q[i] == IDLE) && req_valid[i] &&
                   ((req_type[i] == ERR) || (req_target[i] == '0));
      cand[i]    = ((state_q[i] == IDLE) && req_valid[i] && !badReq[i]) ||
                   (state_q[i] == WAIT);
    end
    for (int o = 0; o < NUM_PORTS; o++) releaseMask[o] = |(outSel_q[o] & xferEop);
  end

  assign freeMask = ~(busy_q & ~releaseMask);

`ifdef SCHED_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] waitCnt_q [NUM_PORTS];
  logic [CW-1:0] waitCnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] urgMask, uGrant, rGrant;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] uOwner, rOwner;
  logic uAny, rAny;
  logic [PW-1:0] uFirst, rFirst;

  // Every output an urgent input wants is withheld from ordinary requesters
  always_comb begin
    urgMask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (starve_q[i]) urgMask = urgMask | req_target[i];
    end
  end

  rr_alloc #(.N(NUM_PORTS), .PW(PW)) u_urgent (
    .cand_i  (cand & starve_q),
    .mask_i  (req_target),
    .free_i  (freeMask),
    .start_i ('0),
    .grant_o (uGrant),
    .owner_o (uOwner),
    .any_o   (uAny),
    .first_o (uFirst)
  );

  rr_alloc #(.N(NUM_PORTS), .PW(PW)) u_rr (
    .cand_i  (cand & ~starve_q),
    .mask_i  (req_target),
    .free_i  (freeMask & ~urgMask),
    .start_i (rrPtr_q),
    .grant_o (rGrant),
    .owner_o (rOwner),
    .any_o   (rAny),
    .first_o (rFirst)
  );

  assign allocGrant = uGrant | rGrant;
  assign allocOwner = uOwner | rOwner;
  assign allocAny   = uAny | rAny;
  assign allocFirst = uAny ? uFirst : rFirst;

  always_comb begin
    starve_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      waitCnt_d[i] = '0;
      if ((state_d[i] == WAIT) && (state_q[i] == WAIT)) begin
        waitCnt_d[i] = (waitCnt_q[i] == CW'(STARVE_LIMIT)) ? waitCnt_q[i]
                                                           : waitCnt_q[i] + CW'(1);
      end
      starve_d[i] = (state_d[i] == WAIT) && (waitCnt_d[i] == CW'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      waitCnt_q[i] <= rst ? '0 : waitCnt_d[i];
    end
  end
`else
  logic unusedStarveLimit;

  rr_alloc #(.N(NUM_PORTS), .PW(PW)) u_rr (
    .cand_i  (cand),
    .mask_i  (req_target),
    .free_i  (freeMask),
    .start_i (rrPtr_q),
    .grant_o (allocGrant),
    .owner_o (allocOwner),
    .any_o   (allocAny),
    .first_o (allocFirst)
  );

  assign starve_d          = '0;
  assign unusedStarveLimit = (STARVE_LIMIT != 0);
`endif

  // A released output may be re-granted in the same cycle, so new ownership wins
  always_comb begin
    grant_d   = allocGrant;
    errDrop_d = badReq;
    outSel_d  = outSel_q;
    busy_d    = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (releaseMask[o]) outSel_d[o] = '0;
      if (|allocOwner[o]) outSel_d[o] = allocOwner[o];
      busy_d[o] = |outSel_d[o];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: begin
          if (allocGrant[i])  state_d[i] = XFER;
          else if (cand[i])   state_d[i] = WAIT;
        end
        WAIT:    if (allocGrant[i]) state_d[i] = XFER;
        XFER:    if (eop[i])        state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
    rrPtr_d = rrPtr_q;
    if (allocAny) rrPtr_d = PW'((int'(allocFirst) + 1) % NUM_PORTS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) state_q[i] <= IDLE;
      rrPtr_q   <= '0;
      grant_q   <= '0;
      errDrop_q <= '0;
      outSel_q  <= '0;
      busy_q    <= '0;
      starve_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) state_q[i] <= state_d[i];
      rrPtr_q   <= rrPtr_d;
      grant_q   <= grant_d;
      errDrop_q <= errDrop_d;
      outSel_q  <= outSel_d;
      busy_q    <= busy_d;
      starve_q  <= starve_d;
    end
  end

  assign grant    = grant_q;
  assign err_drop = errDrop_q;
  assign out_sel  = outSel_q;
  assign out_busy = busy_q;
  assign starve   = starve_q;

endmodule

// File: tb/tb_switch_scheduler.sv
// Self-checking bench for switch_scheduler: table-driven single-cycle vectors plus
// hand-written multi-cycle sequences; the starvation sequence needs SCHED_STARVE_EN.
module tb_switch_scheduler;
  import packet_pkg::*;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [7:0]  typ;
    logic [15:0] tgt;
    logic [3:0]  eop;
    logic [3:0]  expGrant;
    logic [3:0]  expErr;
    logic [15:0] expSel;
    logic [3:0]  expBusy;
  } vec_t;

  localparam int NVEC = 21;

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic [3:0]      reqValid  = '0;
  p_type           reqType [4];
  logic [3:0][3:0] reqTarget = '0;
  logic [3:0]      eopIn     = '0;
  logic [3:0]      grant, errDrop, outBusy, starve;
  logic [3:0][3:0] outSel;

  int   assertCount = 0;
  int   failCount   = 0;
  int   lat;
  vec_t vecs [NVEC];

  switch_scheduler #(.NUM_PORTS(4), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (reqValid),
    .req_type   (reqType),
    .req_target (reqTarget),
    .eop        (eopIn),
    .grant      (grant),
    .err_drop   (errDrop),
    .out_sel    (outSel),
    .out_busy   (outBusy),
    .starve     (starve)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample just after the consuming edge
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [7:0] t,
                               input logic [15:0] tg, input logic [3:0] e);
    rst       = r;
    reqValid  = v;
    reqTarget = tg;
    eopIn     = e;
    for (int i = 0; i < 4; i++) reqType[i] = p_type'(t[2*i +: 2]);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) reqType[i] = SDP;

    //         rst   valid    typ    tgt       eop      grant    err      sel       busy
    vecs[0]  = '{1'b1, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0011, 8'h00, 16'h0044, 4'b0000, 4'b0001, 4'b0000, 16'h0100, 4'b0100};
    vecs[2]  = '{1'b0, 4'b0010, 8'h00, 16'h0044, 4'b0000, 4'b0000, 4'b0000, 16'h0100, 4'b0100};
    vecs[3]  = '{1'b0, 4'b0010, 8'h00, 16'h0044, 4'b0000, 4'b0000, 4'b0000, 16'h0100, 4'b0100};
    vecs[4]  = '{1'b0, 4'b0010, 8'h00, 16'h0044, 4'b0001, 4'b0010, 4'b0000, 16'h0200, 4'b0100};
    vecs[5]  = '{1'b0, 4'b0000, 8'h00, 16'h0000, 4'b0010, 4'b0000, 4'b0000, 16'h0000, 4'b0000};
    vecs[6]  = '{1'b0, 4'b0101, 8'h11, 16'h0906, 4'b0000, 4'b0101, 4'b0000, 16'h4114, 4'b1111};
    vecs[7]  = '{1'b0, 4'b0000, 8'h00, 16'h0000, 4'b0101, 4'b0000, 4'b0000, 16'h0000, 4'b0000};
    vecs[8]  = '{1'b0, 4'b0001, 8'h00, 16'h0002, 4'b0000, 4'b0001, 4'b0000, 16'h0010, 4'b0010};
    vecs[9]  = '{1'b0, 4'b1000, 8'h80, 16'hF000, 4'b0000, 4'b0000, 4'b0000, 16'h0010, 4'b0010};
    vecs[10] = '{1'b0, 4'b1000, 8'h80, 16'hF000, 4'b0000, 4'b0000, 4'b0000, 16'h0010, 4'b0010};
    vecs[11] = '{1'b0, 4'b1000, 8'h80, 16'hF000, 4'b0001, 4'b1000, 4'b0000, 16'h8888, 4'b1111};
    vecs[12] = '{1'b0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 16'h8888, 4'b1111};
    vecs[13] = '{1'b0, 4'b0010, 8'h0C, 16'h0040, 4'b0000, 4'b0000, 4'b0010, 16'h8888, 4'b1111};
    vecs[14] = '{1'b0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 16'h8888, 4'b1111};
    vecs[15] = '{1'b0, 4'b0100, 8'h00, 16'h0000, 4'b0000, 4'b0000, 4'b0100, 16'h8888, 4'b1111};
    vecs[16] = '{1'b0, 4'b0000, 8'h00, 16'h0000, 4'b1000, 4'b0000, 4'b0000, 16'h0000, 4'b0000};
    vecs[17] = '{1'b0, 4'b0011, 8'h00, 16'h0011, 4'b0000, 4'b0001, 4'b0000, 16'h0001, 4'b0001};
    vecs[18] = '{1'b0, 4'b0010, 8'h00, 16'h0011, 4'b0001, 4'b0010, 4'b0000, 16'h0002, 4'b0001};
    vecs[19] = '{1'b1, 4'b0110, 8'h00, 16'h0440, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000};
    vecs[20] = '{1'b0, 4'b0110, 8'h00, 16'h0440, 4'b0000, 4'b0010, 4'b0000, 16'h0200, 4'b0100};

    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(vecs[k].rst, vecs[k].valid, vecs[k].typ, vecs[k].tgt, vecs[k].eop);
      checkOutput($sformatf("vec%0d grant", k),    16'(grant),   16'(vecs[k].expGrant));
      checkOutput($sformatf("vec%0d err_drop", k), 16'(errDrop), 16'(vecs[k].expErr));
      checkOutput($sformatf("vec%0d out_sel", k),  16'(outSel),  vecs[k].expSel);
      checkOutput($sformatf("vec%0d out_busy", k), 16'(outBusy), 16'(vecs[k].expBusy));
      checkOutput($sformatf("vec%0d starve", k),   16'(starve),  16'h0000);
    end

    // in1 holds output 2 while in2 waits; reset mid-transfer must clear everything
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 4'b0100, 8'h00, 16'h0400, 4'b0000);
      checkOutput("hold out_sel", 16'(outSel), 16'h0200);
      checkOutput("hold grant", 16'(grant), 16'h0000);
    end
    applyStimulus(1'b1, 4'b0100, 8'h00, 16'h0400, 4'b0000);
    checkOutput("midreset out_sel", 16'(outSel), 16'h0000);
    checkOutput("midreset out_busy", 16'(outBusy), 16'h0000);
    checkOutput("midreset grant", 16'(grant), 16'h0000);
    applyStimulus(1'b0, 4'b0100, 8'h00, 16'h0400, 4'b0000);
    checkOutput("postreset grant", 16'(grant), 16'h0004);
    checkOutput("postreset out_sel", 16'(outSel), 16'h0400);
    applyStimulus(1'b0, 4'b0000, 8'h00, 16'h0000, 4'b0100);
    checkOutput("postreset release", 16'(outBusy), 16'h0000);

    // Broadcast on an idle switch must be granted with one-cycle latency
    lat = 99;
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(1'b0, 4'b0001, 8'h02, 16'h000F, 4'b0000);
      if (grant[0]) begin
        lat = c;
        break;
      end
    end
    checkOutput("bdp grant latency", 16'(lat), 16'd1);
    checkOutput("bdp out_busy", 16'(outBusy), 16'h000F);
    checkOutput("bdp out_sel", 16'(outSel), 16'h1111);
    applyStimulus(1'b0, 4'b0000, 8'h00, 16'h0000, 4'b0001);
    checkOutput("bdp release", 16'(outBusy), 16'h0000);

`ifdef SCHED_STARVE_EN
    // in0 holds output 0; in1 wants 0011 and must turn urgent, then reserve output 1
    applyStimulus(1'b0, 4'b0001, 8'h00, 16'h0001, 4'b0000);
    checkOutput("starve setup grant", 16'(grant), 16'h0001);
    lat = 99;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1'b0, 4'b0010, 8'h04, 16'h0030, 4'b0000);
      if (starve[1]) begin
        lat = c;
        break;
      end
    end
    checkOutput("starve onset cycles", 16'(lat), 16'd5);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'b0110, 8'h04, 16'h0230, 4'b0000);
      checkOutput("reserve grant", 16'(grant), 16'h0000);
      checkOutput("reserve out_busy", 16'(outBusy), 16'h0001);
      checkOutput("reserve starve", 16'(starve), 16'h0002);
    end
    applyStimulus(1'b0, 4'b0110, 8'h04, 16'h0230, 4'b0001);
    checkOutput("urgent grant", 16'(grant), 16'h0002);
    checkOutput("urgent out_busy", 16'(outBusy), 16'h0003);
    checkOutput("urgent starve clear", 16'(starve), 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
